// File: rtl/eth_dma_ram_if.sv
// Wishbone B3 bus between the Ethernet MAC DMA master and the frame-buffer RAM.
// The master modport is the MAC side and the slave modport is the RAM side.
interface eth_dma_ram_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/eth_dma_ram.sv
// Single-port Wishbone B3 frame-buffer RAM for the Ethernet MAC DMA port.
// Handles classic cycles and registered-feedback incrementing bursts at one beat per clock.
module eth_dma_ram #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter logic [31:0] BASE_ADDR  = 32'h0010_0000
) (
    input logic        wb_clk_i,
    input logic        wb_rst_n_i,
    eth_dma_ram_if.slave wb
);
    typedef logic [ADDR_WIDTH-1:0] waddr_t;
    typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;

    localparam logic [2:0] CTI_INCR   = 3'b010;
    localparam logic [1:0] BTE_LINEAR = 2'b00;

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;
    waddr_t      cur_q, cur_d;
    waddr_t      cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  bte_q, bte_d;
    logic        oow_q, oow_d;

    logic   req;
    logic   beat;
    logic   in_win;
    logic   wr_en;
    logic   rd_en;
    waddr_t idx;
    waddr_t rd_addr;
    logic   unused_adr_lsb;

    // Wrapping bursts only advance the low address bits; linear wraps the whole word index.
    function automatic waddr_t next_addr(input waddr_t w, input logic [1:0] bte);
        waddr_t n;
        n = w;
        case (bte)
            2'b00:   n = w + waddr_t'(1);
            2'b01:   n[1:0] = w[1:0] + 2'd1;
            2'b10:   n[2:0] = w[2:0] + 3'd1;
            default: n[3:0] = w[3:0] + 4'd1;
        endcase
        return n;
    endfunction

    assign req            = wb.wb_cyc_i && wb.wb_stb_i;
    assign beat           = ack_q && req;
    assign in_win         = (wb.wb_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign idx            = wb.wb_adr_i[ADDR_WIDTH+1:2];
    assign wr_en          = beat && we_q;
    assign unused_adr_lsb = ^wb.wb_adr_i[1:0];

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req && !ack_q && !err_q && in_win) begin
                    state_d = (wb.wb_cti_i == CTI_INCR) ? BURST : CLASSIC;
                end
            end
            CLASSIC: state_d = IDLE;
            BURST: begin
                if (!(beat && wb.wb_cti_i == CTI_INCR && !oow_q)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // cnt always holds the address of the beat after the one being acked, so its
    // data can be fetched one cycle early; oow flags that this next address left the window.
    always_comb begin
        ack_d   = 1'b0;
        err_d   = 1'b0;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        bte_d   = bte_q;
        oow_d   = oow_q;
        rd_en   = 1'b0;
        rd_addr = idx;
        case (state_q)
            IDLE: begin
                if (req && !ack_q && !err_q) begin
                    if (!in_win) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d   = 1'b1;
                        cur_d   = idx;
                        cnt_d   = next_addr(idx, wb.wb_bte_i);
                        we_d    = wb.wb_we_i;
                        bte_d   = wb.wb_bte_i;
                        oow_d   = (wb.wb_bte_i == BTE_LINEAR) && (&idx);
                        rd_en   = 1'b1;
                        rd_addr = idx;
                    end
                end
            end
            BURST: begin
                if (beat && wb.wb_cti_i == CTI_INCR) begin
                    if (oow_q) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d   = 1'b1;
                        cur_d   = cnt_q;
                        cnt_d   = next_addr(cnt_q, bte_q);
                        oow_d   = (bte_q == BTE_LINEAR) && (&cnt_q);
                        rd_en   = 1'b1;
                        rd_addr = cnt_q;
                    end
                end
            end
            default: ;
        endcase
        dat_d = dat_q;
        if (rd_en) begin
            dat_d = mem[rd_addr];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            cur_q <= '0;
            cnt_q <= '0;
            we_q  <= 1'b0;
            bte_q <= '0;
            oow_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
            dat_q <= dat_d;
            cur_q <= cur_d;
            cnt_q <= cnt_d;
            we_q  <= we_d;
            bte_q <= bte_d;
            oow_q <= oow_d;
        end
    end

    // Contents are deliberately not reset; frame buffers are always written before use.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wb.wb_sel_i[b]) begin
                    mem[cur_q][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;
endmodule

// File: tb/tb_eth_dma_ram.sv
// Scoreboard bench for eth_dma_ram: classic and burst traffic from a modelled DMA
// master, with expected read data queued from a bench-side memory model.
module tb_eth_dma_ram;
    localparam logic [31:0] BASE = 32'h0010_0000;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    logic [31:0] model [0:2047];
    logic [31:0] exp_q [$];
    logic [31:0] wr_q  [$];

    eth_dma_ram_if bus ();

    eth_dma_ram dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nextWord(input int w, input logic [1:0] bte);
        int m;
        case (bte)
            2'b01:   m = 3;
            2'b10:   m = 7;
            2'b11:   m = 15;
            default: m = 2047;
        endcase
        return (w & ~m) | ((w + 1) & m);
    endfunction

    task automatic expectRead(input int w);
        exp_q.push_back(model[w]);
    endtask

    task automatic popCheck(input string tag);
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            checkOutput(tag, bus.wb_dat_o, exp_q.pop_front());
        end
    endtask

    // One master transaction: beats==1 is a classic cycle, otherwise an incrementing burst.
    task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic [1:0] bte,
                                 input int beats, input logic [3:0] sel, input string tag);
        int          w;
        logic [31:0] d;
        w = int'(adr[12:2]);
        bus.wb_adr_i = adr;
        bus.wb_we_i  = we;
        bus.wb_sel_i = sel;
        bus.wb_bte_i = bte;
        bus.wb_cti_i = (beats == 1) ? 3'b000 : 3'b010;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        for (int i = 0; i < beats; i++) begin
            if (i > 0) begin
                w = nextWord(w, bte);
                bus.wb_adr_i = BASE + 32'(w) * 32'd4;
                if (i == beats - 1) bus.wb_cti_i = 3'b111;
            end
            d = 32'h0;
            if (we && wr_q.size() > 0) d = wr_q.pop_front();
            bus.wb_dat_i = d;
            if (!we) expectRead(w);
            if (i == 0) tick;
            checkOutput({tag, "_ack"}, 32'(bus.wb_ack_o), 32'd1);
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel[b]) model[w][8*b +: 8] = d[8*b +: 8];
                end
            end else begin
                popCheck({tag, "_dat"});
            end
            tick;
        end
        checkOutput({tag, "_end"}, 32'(bus.wb_ack_o), 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cti_i = 3'b000;
    endtask

    task automatic writeWord(input logic [31:0] adr, input logic [31:0] d, input string tag);
        wr_q.push_back(d);
        applyStimulus(adr, 1'b1, 2'b00, 1, 4'hF, tag);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b1;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_cti_i = '0;
        bus.wb_bte_i = '0;
        #2 rst_n = 1'b0;
        #20;
        checkOutput("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        checkOutput("rst_err", 32'(bus.wb_err_o), 32'd0);
        checkOutput("rst_dat", bus.wb_dat_o, 32'd0);
        #10 rst_n = 1'b1;
        tick;

        // Classic write then read back
        writeWord(BASE + 32'h10, 32'hDEAD_BEEF, "cls_wr");
        applyStimulus(BASE + 32'h10, 1'b0, 2'b00, 1, 4'hF, "cls_rd");

        // Byte-lane write
        writeWord(BASE + 32'h10, 32'h1122_3344, "pw_full");
        wr_q.push_back(32'h0000_AA00);
        applyStimulus(BASE + 32'h10, 1'b1, 2'b00, 1, 4'b0010, "pw_part");
        applyStimulus(BASE + 32'h10, 1'b0, 2'b00, 1, 4'hF, "pw_rd");

        // Linear 4-beat write and read
        for (int i = 1; i <= 4; i++) wr_q.push_back(32'(i));
        applyStimulus(BASE + 32'h20, 1'b1, 2'b00, 4, 4'hF, "lin4w");
        applyStimulus(BASE + 32'h20, 1'b0, 2'b00, 4, 4'hF, "lin4r");

        // Wrap4 read starting mid-block
        applyStimulus(BASE + 32'h28, 1'b0, 2'b01, 4, 4'hF, "wrap4r");

        // Out-of-window write is rejected and leaves RAM alone
        writeWord(BASE, 32'hCAFE_F00D, "oow_pre");
        bus.wb_adr_i = 32'h0000_0000;
        bus.wb_dat_i = 32'h1234_5678;
        bus.wb_sel_i = 4'hF;
        bus.wb_we_i  = 1'b1;
        bus.wb_cti_i = 3'b000;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        tick;
        checkOutput("oow_err", 32'(bus.wb_err_o), 32'd1);
        checkOutput("oow_ack", 32'(bus.wb_ack_o), 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        tick;
        checkOutput("oow_err_1cyc", 32'(bus.wb_err_o), 32'd0);
        applyStimulus(BASE, 1'b0, 2'b00, 1, 4'hF, "oow_rd");

        // Linear burst running off the top of the window
        writeWord(BASE + 32'h1FF8, 32'h7777_0001, "top_w0");
        writeWord(BASE + 32'h1FFC, 32'h7777_0002, "top_w1");
        bus.wb_adr_i = BASE + 32'h1FF8;
        bus.wb_bte_i = 2'b00;
        bus.wb_cti_i = 3'b010;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        expectRead(2046);
        tick;
        checkOutput("top_b0_ack", 32'(bus.wb_ack_o), 32'd1);
        popCheck("top_b0_dat");
        bus.wb_adr_i = BASE + 32'h1FFC;
        expectRead(2047);
        tick;
        checkOutput("top_b1_ack", 32'(bus.wb_ack_o), 32'd1);
        popCheck("top_b1_dat");
        tick;
        checkOutput("top_err", 32'(bus.wb_err_o), 32'd1);
        checkOutput("top_err_ack", 32'(bus.wb_ack_o), 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_cti_i = 3'b000;
        tick;
        checkOutput("top_err_1cyc", 32'(bus.wb_err_o), 32'd0);

        // 8-beat write burst where the master drops stb on the 3rd beat
        writeWord(BASE + 32'h48, 32'hA5A5_A5A5, "drop_pre");
        bus.wb_adr_i = BASE + 32'h40;
        bus.wb_dat_i = 32'h0000_00B0;
        bus.wb_sel_i = 4'hF;
        bus.wb_we_i  = 1'b1;
        bus.wb_bte_i = 2'b00;
        bus.wb_cti_i = 3'b010;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        tick;
        checkOutput("drop_b0_ack", 32'(bus.wb_ack_o), 32'd1);
        model[16] = 32'h0000_00B0;
        tick;
        bus.wb_adr_i = BASE + 32'h44;
        bus.wb_dat_i = 32'h0000_00B1;
        checkOutput("drop_b1_ack", 32'(bus.wb_ack_o), 32'd1);
        model[17] = 32'h0000_00B1;
        tick;
        bus.wb_adr_i = BASE + 32'h48;
        bus.wb_dat_i = 32'h0000_00B2;
        bus.wb_stb_i = 1'b0;
        checkOutput("drop_b2_ack", 32'(bus.wb_ack_o), 32'd1);
        tick;
        checkOutput("drop_ack_fall", 32'(bus.wb_ack_o), 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cti_i = 3'b000;
        tick;
        applyStimulus(BASE + 32'h40, 1'b0, 2'b00, 3, 4'hF, "drop_rd");

        // Wrap8 write, linear read-back, then wrap16 read across the block
        for (int i = 0; i < 8; i++) wr_q.push_back(32'h0000_0800 + 32'(i));
        applyStimulus(BASE + 32'h74, 1'b1, 2'b10, 8, 4'hF, "wrap8w");
        applyStimulus(BASE + 32'h60, 1'b0, 2'b00, 8, 4'hF, "lin8r");
        applyStimulus(BASE + 32'h7C, 1'b0, 2'b11, 4, 4'hF, "wrap16r");

        // Reset asserted in the middle of a read burst
        bus.wb_adr_i = BASE + 32'h20;
        bus.wb_we_i  = 1'b0;
        bus.wb_bte_i = 2'b00;
        bus.wb_cti_i = 3'b010;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        expectRead(8);
        tick;
        checkOutput("mid_b0_ack", 32'(bus.wb_ack_o), 32'd1);
        popCheck("mid_b0_dat");
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_ack", 32'(bus.wb_ack_o), 32'd0);
        checkOutput("mid_rst_err", 32'(bus.wb_err_o), 32'd0);
        checkOutput("mid_rst_dat", bus.wb_dat_o, 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_cti_i = 3'b000;
        #2 rst_n = 1'b1;
        tick;
        applyStimulus(BASE + 32'h24, 1'b0, 2'b00, 1, 4'hF, "post_rst_rd");

        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
